id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register. Takes a decoded RV32I instruction plus
// its PC, sign-extended immediate and register-file read data. It selects the
// ALU operands and operation, and presents them registered to the execute
// stage behind a valid/ready handshake. The latency is one cycle.
//
// Optional feature (compile-time macro):
//   RVCORE_FORWARD_EN  When defined, rs1/rs2 operands are bypassed from the
//                      EX/MEM and MEM/WB write-back sources. EX/MEM has
//                      priority. When undefined, the register-file data is
//                      used as is and the forwarding inputs are ignored.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   flush                     drop held and offered instruction
//   in_valid / in_ready       upstream decode handshake
//   instr, pc, imm            decoded instruction, its PC, immediate
//   rs1_data, rs2_data        register-file read data
//   exmem_we/rd/data          EX/MEM forwarding source
//   memwb_we/rd/data          MEM/WB forwarding source
//   out_valid / out_ready     downstream execute handshake
//   alu_d1, alu_d2            ALU operands
//   alu_control               ALU operation
//   rd, reg_write             destination register, write enable
//   pc_out, store_data        instruction PC, store value (rs2)
//   illegal                   unknown opcode flag
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            exmem_we,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_data,
    input  logic            memwb_we,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_d1,
    output logic [XLEN-1:0] alu_d2,
    output logic [3:0]      alu_control,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] store_data,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b1000;

    // ---------------------------------------------------------------------
    // Operand sources: index 0 is rs1, index 1 is rs2
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] src_rf  [2];
    logic [XLEN-1:0] src_val [2];

    assign src_rf[0] = rs1_data;
    assign src_rf[1] = rs2_data;

`ifdef RVCORE_FORWARD_EN
    logic [4:0] src_idx [2];

    assign src_idx[0] = instr[19:15];
    assign src_idx[1] = instr[24:20];

    // x0 is never forwarded. The younger EX/MEM result wins over MEM/WB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign src_val[gi] =
                (exmem_we && (exmem_rd == src_idx[gi]) && (src_idx[gi] != 5'd0)) ? exmem_data :
                (memwb_we && (memwb_rd == src_idx[gi]) && (src_idx[gi] != 5'd0)) ? memwb_data :
                src_rf[gi];
        end
    endgenerate

    // Instruction bits that carry no information for this stage.
    logic unused_bits;
    assign unused_bits = ^{instr[31], instr[29:25]};
`else
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign src_val[gi] = src_rf[gi];
        end
    endgenerate

    // Register indices and forwarding sources do not matter without bypass.
    logic unused_bits;
    assign unused_bits = ^{instr[31], instr[29:15],
                           exmem_we, exmem_rd, exmem_data,
                           memwb_we, memwb_rd, memwb_data};
`endif

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [3:0]      alu_control_next;
    logic [XLEN-1:0] alu_d1_next;
    logic [XLEN-1:0] alu_d2_next;
    logic            reg_write_next;
    logic            illegal_next;
    logic [4:0]      rd_next;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        alu_control_next = ALU_ADD;
        alu_d1_next      = src_val[0];
        alu_d2_next      = imm;
        reg_write_next   = 1'b1;
        illegal_next     = 1'b0;
        case (opcode)
            OPC_OP: begin
                // instr[30] selects SUB/SRA. For other funct3 values it is
                // not part of the operation.
                alu_control_next = {instr[30] && ((funct3 == 3'b000) || (funct3 == 3'b101)), funct3};
                alu_d2_next      = src_val[1];
            end
            OPC_OPIMM: begin
                // For ADDI, instr[30] is an immediate bit. Only SRAI uses it.
                alu_control_next = {instr[30] && (funct3 == 3'b101), funct3};
            end
            OPC_BRANCH: begin
                reg_write_next = 1'b0;
                alu_d2_next    = src_val[1];
                case (funct3[2:1])
                    2'b10:   alu_control_next = ALU_SLT;
                    2'b11:   alu_control_next = ALU_SLTU;
                    default: alu_control_next = ALU_SUB;
                endcase
            end
            OPC_LOAD, OPC_JALR: begin
            end
            OPC_STORE: begin
                reg_write_next = 1'b0;
            end
            OPC_JAL, OPC_AUIPC: begin
                alu_d1_next = pc;
            end
            OPC_LUI: begin
                alu_d1_next = '0;
            end
            default: begin
                illegal_next   = 1'b1;
                reg_write_next = 1'b0;
            end
        endcase
        rd_next = reg_write_next ? instr[11:7] : 5'd0;
    end

    // ---------------------------------------------------------------------
    // Handshake and pipeline register
    // ---------------------------------------------------------------------
    logic            out_valid_reg;
    logic [XLEN-1:0] alu_d1_reg;
    logic [XLEN-1:0] alu_d2_reg;
    logic [3:0]      alu_control_reg;
    logic [4:0]      rd_reg;
    logic            reg_write_reg;
    logic [XLEN-1:0] pc_out_reg;
    logic [XLEN-1:0] store_data_reg;
    logic            illegal_reg;
    logic            capture;

    assign in_ready = !flush && (!out_valid_reg || out_ready);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            alu_d1_reg      <= '0;
            alu_d2_reg      <= '0;
            alu_control_reg <= '0;
            rd_reg          <= '0;
            reg_write_reg   <= 1'b0;
            pc_out_reg      <= '0;
            store_data_reg  <= '0;
            illegal_reg     <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (capture) begin
            out_valid_reg   <= 1'b1;
            alu_d1_reg      <= alu_d1_next;
            alu_d2_reg      <= alu_d2_next;
            alu_control_reg <= alu_control_next;
            rd_reg          <= rd_next;
            reg_write_reg   <= reg_write_next;
            pc_out_reg      <= pc;
            store_data_reg  <= src_val[1];
            illegal_reg     <= illegal_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign alu_d1      = alu_d1_reg;
    assign alu_d2      = alu_d2_reg;
    assign alu_control = alu_control_reg;
    assign rd          = rd_reg;
    assign reg_write   = reg_write_reg;
    assign pc_out      = pc_out_reg;
    assign store_data  = store_data_reg;
    assign illegal     = illegal_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. It applies a table of directed decode
// vectors, then hand-written handshake, flush, reset and forwarding sequences.
// It ends with randomized traffic that is compared against a behavioural model.
// The model follows RVCORE_FORWARD_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BR     = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, pc, imm, rs1_data, rs2_data;
    logic        exmem_we, memwb_we;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic [31:0] alu_d1, alu_d2, pc_out, store_data;
    logic [3:0]  alu_control;
    logic [4:0]  rd;
    logic        reg_write, illegal;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .imm(imm),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_control(alu_control),
        .rd(rd), .reg_write(reg_write), .pc_out(pc_out),
        .store_data(store_data), .illegal(illegal)
    );

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] pc_out;
        logic [31:0] sd;
        logic        ill;
    } pay_t;

    typedef struct {
        string       name;
        logic [31:0] instr, pc, imm, rs1, rs2;
        pay_t        exp;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic checkb(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkp(input string name, input pay_t got, input pay_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got d1=%h d2=%h alu=%b rd=%0d rw=%b pc=%h sd=%h ill=%b expected d1=%h d2=%h alu=%b rd=%0d rw=%b pc=%h sd=%h ill=%b",
                     name, got.d1, got.d2, got.alu, got.rd, got.rw, got.pc_out, got.sd, got.ill,
                     exp.d1, exp.d2, exp.alu, exp.rd, exp.rw, exp.pc_out, exp.sd, exp.ill);
        end
    endtask

    function automatic pay_t dut_pay();
        pay_t p;
        p = {alu_d1, alu_d2, alu_control, rd, reg_write, pc_out, store_data, illegal};
        return p;
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rdf, input logic [6:0] opc);
        return {f7, r2, r1, f3, rdf, opc};
    endfunction

    task automatic add_vec(input string n, input logic [31:0] ins, input logic [31:0] p, input logic [31:0] im,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_d1, input logic [31:0] e_d2, input logic [3:0] e_alu,
                           input logic [4:0] e_rd, input logic e_rw, input logic e_ill);
        vec_t v;
        v.name = n; v.instr = ins; v.pc = p; v.imm = im; v.rs1 = a; v.rs2 = b;
        v.exp  = {e_d1, e_d2, e_alu, e_rd, e_rw, p, b, e_ill};
        vq.push_back(v);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v; instr = ins; pc = p; imm = im; rs1_data = a; rs2_data = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef RVCORE_FORWARD_EN
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs != 5'd0 && exmem_we && exmem_rd == rs) return exmem_data;
        if (rs != 5'd0 && memwb_we && memwb_rd == rs) return memwb_data;
        return rf;
    endfunction
`endif

    // Reference decode of the currently driven instruction.
    function automatic pay_t model();
        pay_t        p;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] a, b;
        bit          legal;
        opc = instr[6:0];
        f3  = instr[14:12];
        a   = rs1_data;
        b   = rs2_data;
`ifdef RVCORE_FORWARD_EN
        a = fwd(instr[19:15], rs1_data);
        b = fwd(instr[24:20], rs2_data);
`endif
        legal = opc inside {OPC_OP, OPC_OPIMM, OPC_BR, OPC_LOAD, OPC_STORE,
                            OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI};
        p        = '0;
        p.pc_out = pc;
        p.sd     = b;
        p.ill    = !legal;
        p.rw     = legal && opc != OPC_STORE && opc != OPC_BR;
        p.rd     = p.rw ? instr[11:7] : 5'd0;
        if (opc == OPC_OP)
            p.alu = (instr[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 4'(8 + f3) : {1'b0, f3};
        else if (opc == OPC_OPIMM)
            p.alu = (instr[30] && f3 == 3'd5) ? 4'd13 : {1'b0, f3};
        else if (opc == OPC_BR)
            p.alu = (f3 < 3'd2) ? 4'd8 : (f3 < 3'd6) ? 4'd2 : 4'd3;
        else
            p.alu = 4'd0;
        p.d1 = (opc == OPC_AUIPC || opc == OPC_JAL) ? pc : (opc == OPC_LUI) ? 32'd0 : a;
        p.d2 = (opc == OPC_OP || opc == OPC_BR) ? b : imm;
        return p;
    endfunction

    function automatic logic [31:0] rand_instr();
        int          k;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] r;
        k = $urandom_range(0, 10);
        r = $urandom;
        case (k)
            0: opc = OPC_OP;     1: opc = OPC_OPIMM; 2: opc = OPC_BR;
            3: opc = OPC_LOAD;   4: opc = OPC_STORE; 5: opc = OPC_JAL;
            6: opc = OPC_JALR;   7: opc = OPC_AUIPC; 8: opc = OPC_LUI;
            9: opc = OPC_BAD;    default: opc = 7'b0001011;
        endcase
        f3 = 3'($urandom_range(0, 7));
        if (opc == OPC_BR && (f3 == 3'd2 || f3 == 3'd3)) f3 = f3 + 3'd2;
        return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3, r[11:7], opc};
    endfunction

    pay_t exp_pay, sub_exp, add_exp;
    logic exp_valid, exp_ready, chk_zero;
    int   txn = 0;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        exmem_we = 1'b0; exmem_rd = 5'd0; exmem_data = 32'd0;
        memwb_we = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;

        // ---------------- directed decode table ----------------
        add_vec("add",   enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP),    32'h100, 32'h0, 32'd5, 32'd7,
                32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);
        add_vec("sub",   enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd6, OPC_OP),    32'h104, 32'h0, 32'd20, 32'd9,
                32'd20, 32'd9, 4'b1000, 5'd6, 1'b1, 1'b0);
        add_vec("sra",   enc(7'h20, 5'd2, 5'd1, 3'd5, 5'd7, OPC_OP),    32'h108, 32'h0, 32'h80000000, 32'd4,
                32'h80000000, 32'd4, 4'b1101, 5'd7, 1'b1, 1'b0);
        add_vec("xor30", enc(7'h20, 5'd2, 5'd1, 3'd4, 5'd8, OPC_OP),    32'h10c, 32'h0, 32'd1, 32'd2,
                32'd1, 32'd2, 4'b0100, 5'd8, 1'b1, 1'b0);
        add_vec("sltu",  enc(7'h00, 5'd2, 5'd1, 3'd3, 5'd9, OPC_OP),    32'h110, 32'h0, 32'd3, 32'd4,
                32'd3, 32'd4, 4'b0011, 5'd9, 1'b1, 1'b0);
        add_vec("srai",  enc(7'h20, 5'd3, 5'd1, 3'd5, 5'd4, OPC_OPIMM), 32'h114, 32'd3, 32'h40, 32'h55,
                32'h40, 32'd3, 4'b1101, 5'd4, 1'b1, 1'b0);
        add_vec("addi30",enc(7'h20, 5'd0, 5'd1, 3'd0, 5'd10, OPC_OPIMM),32'h118, 32'hfffffc00, 32'd9, 32'd1,
                32'd9, 32'hfffffc00, 4'b0000, 5'd10, 1'b1, 1'b0);
        add_vec("slli",  enc(7'h00, 5'd2, 5'd1, 3'd1, 5'd11, OPC_OPIMM),32'h11c, 32'd2, 32'd6, 32'd1,
                32'd6, 32'd2, 4'b0001, 5'd11, 1'b1, 1'b0);
        add_vec("bltu",  enc(7'h00, 5'd2, 5'd1, 3'd6, 5'd9, OPC_BR),    32'h120, 32'h40, 32'd3, 32'd8,
                32'd3, 32'd8, 4'b0011, 5'd0, 1'b0, 1'b0);
        add_vec("beq",   enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd4, OPC_BR),    32'h124, 32'h40, 32'd3, 32'd3,
                32'd3, 32'd3, 4'b1000, 5'd0, 1'b0, 1'b0);
        add_vec("bge",   enc(7'h00, 5'd2, 5'd1, 3'd5, 5'd4, OPC_BR),    32'h128, 32'h40, 32'd1, 32'd2,
                32'd1, 32'd2, 4'b0010, 5'd0, 1'b0, 1'b0);
        add_vec("lw",    enc(7'h00, 5'd0, 5'd1, 3'd2, 5'd11, OPC_LOAD), 32'h12c, 32'h10, 32'h1000, 32'd5,
                32'h1000, 32'h10, 4'b0000, 5'd11, 1'b1, 1'b0);
        add_vec("sw",    enc(7'h00, 5'd2, 5'd1, 3'd2, 5'd5, OPC_STORE), 32'h130, 32'h8, 32'h2000, 32'hdead,
                32'h2000, 32'h8, 4'b0000, 5'd0, 1'b0, 1'b0);
        add_vec("jal",   enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, OPC_JAL),   32'h400, 32'h20, 32'd7, 32'd8,
                32'h400, 32'h20, 4'b0000, 5'd1, 1'b1, 1'b0);
        add_vec("jalr",  enc(7'h00, 5'd0, 5'd2, 3'd0, 5'd1, OPC_JALR),  32'h404, 32'd4, 32'h1000, 32'd8,
                32'h1000, 32'd4, 4'b0000, 5'd1, 1'b1, 1'b0);
        add_vec("auipc", enc(7'h00, 5'd0, 5'd0, 3'd0, 5'd12, OPC_AUIPC),32'h500, 32'h1000, 32'd7, 32'd8,
                32'h500, 32'h1000, 4'b0000, 5'd12, 1'b1, 1'b0);
        add_vec("lui",   enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd13, OPC_LUI),  32'h504, 32'h12345000, 32'h77, 32'd8,
                32'd0, 32'h12345000, 4'b0000, 5'd13, 1'b1, 1'b0);
        add_vec("illegal",enc(7'h20, 5'd2, 5'd1, 3'd5, 5'd14, OPC_BAD), 32'h508, 32'h33, 32'h11, 32'h22,
                32'h11, 32'h33, 4'b0000, 5'd0, 1'b0, 1'b1);

        // ---------------- reset state ----------------
        repeat (2) step();
        checkb("reset_valid", out_valid, 1'b0);
        checkp("reset_payload", dut_pay(), '0);
        rst = 1'b0;
        #1;
        checkb("ready_after_reset", in_ready, 1'b1);

        // ---------------- table, back-to-back with out_ready=1 ----------------
        step();
        out_ready = 1'b1;
        foreach (vq[i]) begin
            drive(1'b1, vq[i].instr, vq[i].pc, vq[i].imm, vq[i].rs1, vq[i].rs2);
            step();
            checkb({vq[i].name, "_valid"}, out_valid, 1'b1);
            checkp(vq[i].name, dut_pay(), vq[i].exp);
            $display("txn %0d %s alu=%b d1=%h d2=%h rd=%0d rw=%b ill=%b",
                     txn++, vq[i].name, alu_control, alu_d1, alu_d2, rd, reg_write, illegal);
        end
        in_valid = 1'b0;
        step();
        checkb("drain_valid", out_valid, 1'b0);

        // ---------------- backpressure: sub held for 3 cycles ----------------
        sub_exp = {32'd20, 32'd9, 4'b1000, 5'd6, 1'b1, 32'h200, 32'd9, 1'b0};
        add_exp = {32'd1, 32'd2, 4'b0000, 5'd3, 1'b1, 32'h204, 32'd2, 1'b0};
        out_ready = 1'b0;
        drive(1'b1, enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd6, OPC_OP), 32'h200, 32'd0, 32'd20, 32'd9);
        step();
        drive(1'b1, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP), 32'h204, 32'd0, 32'd1, 32'd2);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkb("stall_in_ready", in_ready, 1'b0);
            checkb("stall_valid", out_valid, 1'b1);
            checkp("stall_payload", dut_pay(), sub_exp);
            step();
        end
        out_ready = 1'b1;
        #1;
        checkb("release_in_ready", in_ready, 1'b1);
        step();
        checkp("release_capture", dut_pay(), add_exp);
        $display("txn %0d stall_release alu=%b d1=%h d2=%h", txn++, alu_control, alu_d1, alu_d2);
        in_valid = 1'b0;
        step();
        checkb("release_drain", out_valid, 1'b0);

        // ---------------- flush ----------------
        drive(1'b1, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP), 32'h300, 32'd0, 32'd1, 32'd2);
        step();
        checkb("pre_flush_valid", out_valid, 1'b1);
        flush = 1'b1;
        drive(1'b1, enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd6, OPC_OP), 32'h304, 32'd0, 32'd3, 32'd4);
        #1;
        checkb("flush_in_ready", in_ready, 1'b0);
        step();
        checkb("flush_valid", out_valid, 1'b0);
        flush = 1'b0;
        out_ready = 1'b0;
        step();
        checkb("flush_drop_then_capture", out_valid, 1'b1);
        flush = 1'b1;
        in_valid = 1'b0;
        step();
        checkb("flush_held_valid", out_valid, 1'b0);
        flush = 1'b0;

        // ---------------- reset mid-handshake ----------------
        drive(1'b1, enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP), 32'h320, 32'd5, 32'd1, 32'd2);
        step();
        checkb("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        flush = 1'b1;
        step();
        checkb("rst_valid", out_valid, 1'b0);
        checkp("rst_payload", dut_pay(), '0);
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checkb("rst_release_ready", in_ready, 1'b1);
        out_ready = 1'b1;

        // ---------------- forwarding: add x5,x1,x0 ----------------
        exmem_we = 1'b1; exmem_rd = 5'd1; exmem_data = 32'haa;
        memwb_we = 1'b1; memwb_rd = 5'd1; memwb_data = 32'hbb;
        drive(1'b1, enc(7'h00, 5'd0, 5'd1, 3'd0, 5'd5, OPC_OP), 32'h340, 32'd0, 32'h11, 32'h22);
        step();
`ifdef RVCORE_FORWARD_EN
        check32("fwd_double_d1", alu_d1, 32'haa);
`else
        check32("fwd_double_d1", alu_d1, 32'h11);
`endif
        check32("fwd_x0_d2", alu_d2, 32'h22);
        exmem_we = 1'b0;
        step();
`ifdef RVCORE_FORWARD_EN
        check32("fwd_memwb_d1", alu_d1, 32'hbb);
`else
        check32("fwd_memwb_d1", alu_d1, 32'h11);
`endif
        exmem_we = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        step();
        check32("fwd_rd0_d1", alu_d1, 32'h11);
        exmem_we = 1'b0; memwb_we = 1'b0;
        in_valid = 1'b0;
        step();

        // ---------------- randomized traffic vs. model ----------------
        exp_valid = 1'b0;
        exp_pay   = '0;
        chk_zero  = 1'b0;
        for (int n = 0; n < 600; n++) begin
            checkb("rand_valid", out_valid, exp_valid);
            if (exp_valid || chk_zero) checkp("rand_payload", dut_pay(), exp_pay);

            rst        = ($urandom_range(0, 49) == 0);
            flush      = ($urandom_range(0, 11) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            instr      = rand_instr();
            pc         = $urandom;
            imm        = $urandom;
            rs1_data   = $urandom;
            rs2_data   = $urandom;
            exmem_we   = ($urandom_range(0, 1) == 1);
            exmem_rd   = 5'($urandom_range(0, 3));
            exmem_data = $urandom;
            memwb_we   = ($urandom_range(0, 1) == 1);
            memwb_rd   = 5'($urandom_range(0, 3));
            memwb_data = $urandom;
            #1;
            exp_ready = !flush && (!exp_valid || out_ready);
            checkb("rand_in_ready", in_ready, exp_ready);

            chk_zero = 1'b0;
            if (rst) begin
                exp_valid = 1'b0;
                exp_pay   = '0;
                chk_zero  = 1'b1;
            end else if (flush) begin
                exp_valid = 1'b0;
            end else if (in_valid && exp_ready) begin
                exp_valid = 1'b1;
                exp_pay   = model();
                $display("txn %0d rand instr=%h alu=%b d1=%h d2=%h rd=%0d ill=%b",
                         txn++, instr, exp_pay.alu, exp_pay.d1, exp_pay.d2, exp_pay.rd, exp_pay.ill);
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
            step();
        end
        checkb("rand_final_valid", out_valid, exp_valid);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
